intersection_sched: RTL and testbench
=====================================

INTERSECTION_SCHED -- requirements
Module: intersection_sched

Interface
REQ-001 SHALL have parameter GREEN_TICKS, default 8, green duration in Tick pulses (legal 1..255).
REQ-002 SHALL have parameter YELLOW_TICKS, default 3, yellow duration in Tick pulses (legal 1..255).
REQ-003 SHALL have parameter ALLRED_TICKS, default 1, all-red clearance duration in Tick pulses (legal 1..255).
REQ-004 SHALL have parameter WALK_TICKS, default 6, pedestrian phase duration in Tick pulses (legal 1..255).
REQ-005 SHALL have ports, one clock and asynchronous active-low reset:
- Clk  in  1  sole clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Tick  in  1  one-Clk timebase enable pulse.
- Walk  in  1  asynchronous pedestrian button, active-high.
- LED_NS  out  3  north-south lamps {R,Y,G}.
- LED_EW  out  3  east-west lamps {R,Y,G}.
- Walk_LED  out  1  pedestrian walk lamp.
- Walk_Pending  out  1  request latched, not yet served.
- Phase  out  3  current state code, for debug.

Function
REQ-006 SHALL implement states INIT, NS_G, NS_Y, RED_A, EW_G, EW_Y, RED_B, WALK.
REQ-007 SHALL transition INIT->NS_G, NS_G->NS_Y, NS_Y->RED_A, EW_G->EW_Y, EW_Y->RED_B, with every transition on timer expiry only.
REQ-008 SHALL, at RED_A expiry, go to WALK if Walk_Pending=1, else EW_G; at RED_B expiry, go to WALK if Walk_Pending=1, else NS_G.
REQ-009 SHALL, at WALK expiry, go to EW_G if entered from RED_A and NS_G if entered from RED_B, using a one-bit next-direction flop.
REQ-010 SHALL load the 8-bit timer with the state duration on state entry, decrement it on each Tick, and expire on a cycle with Tick=1 and count=1; each state lasts exactly N Ticks. INIT duration SHALL be 1.
REQ-011 SHALL drive lamps as a Moore function of state: NS_G -> LED_NS=001, LED_EW=100; NS_Y -> 010/100; EW_G -> 100/001; EW_Y -> 100/010; all other states -> 100/100.
REQ-012 SHALL assert Walk_LED only in WALK; no state SHALL light a green or yellow lamp concurrently with Walk_LED.
REQ-013 SHALL synchronise Walk through two flops and set Walk_Pending on the synchronised rising edge, within 3 Clk of the button edge.
REQ-014 SHALL clear Walk_Pending on the Clk edge that enters WALK; a press edge coincident with that edge SHALL be absorbed (cleared), and press edges during WALK SHALL be ignored.
REQ-015 SHALL count a held button once; a re-press while pending SHALL have no effect.
REQ-016 SHALL ignore Tick-free cycles: state and timer SHALL hold indefinitely without Tick.
REQ-017 SHALL flag parameter values outside 1..255 with an elaboration-time error.

Reset
REQ-018 SHALL, while Reset_n=0, force state INIT, timer=1, LED_NS=100, LED_EW=100, Walk_LED=0, Walk_Pending=0, synchroniser flops=0, and next-direction=EW.
REQ-019 SHALL abort any phase immediately on a mid-operation reset, reaching all-red asynchronously.
REQ-020 SHALL release reset synchronously via a two-flop reset synchroniser internal to the block.

Structure
REQ-021 SHALL place the state enum (3-bit), the lamp constants (RED=100, YEL=010, GRN=001) and the Phase encoding in shared package traffic_pkg.
REQ-022 SHALL factor the button synchroniser, edge detector and pending latch into sub-module walk_req.

Verification (GREEN=5, YELLOW=2, ALLRED=1, WALK=4, Tick every 4 Clk)
REQ-023 SHALL cover free run with no press: INIT(1)->NS_G(5)->NS_Y(2)->RED_A(1)->EW_G(5)->EW_Y(2)->RED_B(1)->NS_G, with lamps exactly per REQ-011 and a cycle of 16 Ticks.
REQ-024 SHALL cover a press during NS_G: Walk_Pending=1 within 3 Clk, WALK follows RED_A for 4 Ticks with Walk_LED=1 and all lamps 100, then EW_G, and Walk_Pending=0 on WALK entry.
REQ-025 SHALL cover a press held 40 Clk plus a re-press during WALK: exactly one WALK is served, and the next RED_B goes directly to NS_G.
REQ-026 SHALL cover Reset_n low mid-EW_G: LED_EW=100 and Walk_Pending=0 asynchronously, then after release NS_G follows INIT after one Tick.
REQ-027 SHALL cover Tick held low for 100 Clk in NS_Y: state and lamps unchanged, and the remaining count resumes correctly.
REQ-028 SHALL cover a press edge on the same Clk edge as WALK entry: Walk_Pending ends at 0 and no second WALK occurs.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared definitions for the intersection scheduler.
//   state_e     - 3-bit controller state; its numeric value is the Phase debug code.
//   Lamp*       - lamp triplets ordered {R,Y,G}.
//   Dir*        - value of the next-direction flop.
//   lamp_ns/ew  - Moore lamp decode per state.
//   phase_code  - Phase output encoding.
package traffic_pkg;

    typedef enum logic [2:0] {
        StInit = 3'd0,
        StNsG  = 3'd1,
        StNsY  = 3'd2,
        StRedA = 3'd3,
        StEwG  = 3'd4,
        StEwY  = 3'd5,
        StRedB = 3'd6,
        StWalk = 3'd7
    } state_e;

    localparam logic [2:0] LampRed = 3'b100;
    localparam logic [2:0] LampYel = 3'b010;
    localparam logic [2:0] LampGrn = 3'b001;

    // Direction served after a pedestrian phase.
    localparam logic DirEw = 1'b0;
    localparam logic DirNs = 1'b1;

    function automatic logic [2:0] lamp_ns(state_e s);
        case (s)
            StNsG:   return LampGrn;
            StNsY:   return LampYel;
            default: return LampRed;
        endcase
    endfunction

    function automatic logic [2:0] lamp_ew(state_e s);
        case (s)
            StEwG:   return LampGrn;
            StEwY:   return LampYel;
            default: return LampRed;
        endcase
    endfunction

    function automatic logic [2:0] phase_code(state_e s);
        return s;
    endfunction

endpackage

// File: rtl/walk_req.sv
// walk_req: pedestrian request front end.
//   Two-flop synchroniser for the asynchronous button, rising-edge detect and a
//   pending latch. A held button counts once; edges while blocked are dropped;
//   clear wins over a coincident edge so that edge is absorbed.
// Ports:
//   i_clk      clock
//   i_rst_n    asynchronous active-low reset
//   i_walk     raw asynchronous button
//   i_clr      clear pending (controller is entering the walk phase)
//   i_block    ignore new edges (controller is in the walk phase)
//   o_pending  request latched, not yet served
module walk_req (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_walk,
    input  logic i_clr,
    input  logic i_block,
    output logic o_pending
);

    logic r_meta;
    logic r_sync;
    logic r_sync_prev;
    logic r_pending;
    logic w_rise;
    logic w_pending_nxt;

    assign w_rise = r_sync & ~r_sync_prev;

    always_comb begin
        w_pending_nxt = r_pending;
        if (i_clr) begin
            w_pending_nxt = 1'b0;
        end else if (w_rise && !i_block) begin
            w_pending_nxt = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta      <= 1'b0;
            r_sync      <= 1'b0;
            r_sync_prev <= 1'b0;
            r_pending   <= 1'b0;
        end else begin
            r_meta      <= i_walk;
            r_sync      <= r_meta;
            r_sync_prev <= r_sync;
            r_pending   <= w_pending_nxt;
        end
    end

    assign o_pending = r_pending;

endmodule

// File: rtl/intersection_sched.sv
// intersection_sched: two-way traffic-light scheduler with a pedestrian phase.
//   Cycle NS_G -> NS_Y -> RED_A -> EW_G -> EW_Y -> RED_B -> NS_G, with a WALK
//   phase inserted after either all-red when a request is pending. Every state
//   lasts a fixed number of Tick pulses; without Tick nothing moves.
// Ports:
//   Clk           clock, rising edge
//   Reset_n       asynchronous active-low reset (assert async, release sync)
//   Tick          one-Clk timebase enable
//   Walk          asynchronous pedestrian button, active-high
//   LED_NS/LED_EW lamps {R,Y,G}
//   Walk_LED      pedestrian walk lamp
//   Walk_Pending  request latched, not yet served
//   Phase         current state code
module intersection_sched
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_TICKS  = 8,
    parameter int unsigned YELLOW_TICKS = 3,
    parameter int unsigned ALLRED_TICKS = 1,
    parameter int unsigned WALK_TICKS   = 6
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Tick,
    input  logic       Walk,
    output logic [2:0] LED_NS,
    output logic [2:0] LED_EW,
    output logic       Walk_LED,
    output logic       Walk_Pending,
    output logic [2:0] Phase
);

    if (GREEN_TICKS < 1 || GREEN_TICKS > 255 || YELLOW_TICKS < 1 || YELLOW_TICKS > 255 ||
        ALLRED_TICKS < 1 || ALLRED_TICKS > 255 || WALK_TICKS < 1 || WALK_TICKS > 255)
    begin : g_bad_param
        $error("intersection_sched: every *_TICKS parameter must be in 1..255");
    end

    function automatic logic [7:0] duration(state_e s);
        case (s)
            StNsG, StEwG:   duration = 8'(GREEN_TICKS);
            StNsY, StEwY:   duration = 8'(YELLOW_TICKS);
            StRedA, StRedB: duration = 8'(ALLRED_TICKS);
            StWalk:         duration = 8'(WALK_TICKS);
            default:        duration = 8'd1;
        endcase
    endfunction

    // Reset asserts immediately and releases two clocks after Reset_n rises.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    state_e     r_state;
    state_e     w_state_nxt;
    logic [7:0] r_timer;
    logic [7:0] w_timer_nxt;
    logic       r_dir;
    logic       w_dir_nxt;
    logic [2:0] r_led_ns;
    logic [2:0] r_led_ew;
    logic       r_walk_led;
    logic       w_pending;
    logic       w_enter_walk;
    logic       w_in_walk;

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        if (Tick) begin
            if (r_timer == 8'd1) begin
                case (r_state)
                    StInit:  w_state_nxt = StNsG;
                    StNsG:   w_state_nxt = StNsY;
                    StNsY:   w_state_nxt = StRedA;
                    StRedA:  w_state_nxt = w_pending ? StWalk : StEwG;
                    StEwG:   w_state_nxt = StEwY;
                    StEwY:   w_state_nxt = StRedB;
                    StRedB:  w_state_nxt = w_pending ? StWalk : StNsG;
                    StWalk:  w_state_nxt = (r_dir == DirNs) ? StNsG : StEwG;
                    default: w_state_nxt = StInit;
                endcase
                w_timer_nxt = duration(w_state_nxt);
            end else begin
                w_timer_nxt = r_timer - 8'd1;
            end
        end
    end

    assign w_in_walk    = (r_state == StWalk);
    assign w_enter_walk = (w_state_nxt == StWalk) && !w_in_walk;

    // Remember which all-red led into WALK so the opposite road is served next.
    always_comb begin
        w_dir_nxt = r_dir;
        if (w_enter_walk) begin
            w_dir_nxt = (r_state == StRedB) ? DirNs : DirEw;
        end
    end

    // Lamps are registered from the next state so they change with the state.
    always_ff @(posedge Clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= StInit;
            r_timer    <= 8'd1;
            r_dir      <= DirEw;
            r_led_ns   <= LampRed;
            r_led_ew   <= LampRed;
            r_walk_led <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_dir      <= w_dir_nxt;
            r_led_ns   <= lamp_ns(w_state_nxt);
            r_led_ew   <= lamp_ew(w_state_nxt);
            r_walk_led <= (w_state_nxt == StWalk);
        end
    end

    walk_req u_walk_req (
        .i_clk     (Clk),
        .i_rst_n   (w_rst_n),
        .i_walk    (Walk),
        .i_clr     (w_enter_walk),
        .i_block   (w_in_walk),
        .o_pending (w_pending)
    );

    assign LED_NS       = r_led_ns;
    assign LED_EW       = r_led_ew;
    assign Walk_LED     = r_walk_led;
    assign Walk_Pending = w_pending;
    assign Phase        = phase_code(r_state);

endmodule

// File: tb/tb_intersection_sched.sv
// tb_intersection_sched: scenario tasks plus randomized traffic against a
// tick-level behavioural model of the scheduler.
module tb_intersection_sched;
    import traffic_pkg::*;

    localparam int G = 5;
    localparam int Y = 2;
    localparam int A = 1;
    localparam int W = 4;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       Tick;
    logic       Walk;
    logic [2:0] LED_NS;
    logic [2:0] LED_EW;
    logic       Walk_LED;
    logic       Walk_Pending;
    logic [2:0] Phase;

    intersection_sched #(
        .GREEN_TICKS  (G),
        .YELLOW_TICKS (Y),
        .ALLRED_TICKS (A),
        .WALK_TICKS   (W)
    ) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Tick         (Tick),
        .Walk         (Walk),
        .LED_NS       (LED_NS),
        .LED_EW       (LED_EW),
        .Walk_LED     (Walk_LED),
        .Walk_Pending (Walk_Pending),
        .Phase        (Phase)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state.
    state_e m_st;
    int     m_left;
    bit     m_dir_ns;
    bit     m_pend;
    bit     m_wprev;
    int     m_edge = 0;
    int     m_q[$];   // clock edge numbers at which a button press takes effect

    // Observations of the DUT.
    int         slot = 0;
    bit         last_was_tick;
    int         n_tick = 0;
    int         obs_walks = 0;
    logic       obs_prev_walk_led = 1'b0;
    logic [2:0] obs_prev_phase = 3'd0;
    bit         phase_changed;
    logic [2:0] after_walk;
    logic [2:0] after_redb;
    int         ns_entry_last = -1;
    int         ns_entry_prev = -1;

    function automatic int dur_of(state_e s);
        case (s)
            StNsG, StEwG:   return G;
            StNsY, StEwY:   return Y;
            StRedA, StRedB: return A;
            StWalk:         return W;
            default:        return 1;
        endcase
    endfunction

    function automatic state_e succ(state_e s, bit pend, bit dir_ns);
        case (s)
            StInit:  return StNsG;
            StNsG:   return StNsY;
            StNsY:   return StRedA;
            StRedA:  return pend ? StWalk : StEwG;
            StEwG:   return StEwY;
            StEwY:   return StRedB;
            StRedB:  return pend ? StWalk : StNsG;
            StWalk:  return dir_ns ? StNsG : StEwG;
            default: return StInit;
        endcase
    endfunction

    function automatic logic [10:0] expect_vec();
        logic [2:0] ns;
        logic [2:0] ew;
        logic [2:0] ph;
        logic       wl;
        ns = 3'b100;
        ew = 3'b100;
        wl = 1'b0;
        case (m_st)
            StNsG:   ns = 3'b001;
            StNsY:   ns = 3'b010;
            StEwG:   ew = 3'b001;
            StEwY:   ew = 3'b010;
            StWalk:  wl = 1'b1;
            default: ;
        endcase
        ph = m_st;
        return {ns, ew, wl, m_pend, ph};
    endfunction

    task automatic model_reset();
        m_st              = StInit;
        m_left            = 1;
        m_dir_ns          = 1'b0;
        m_pend            = 1'b0;
        m_wprev           = 1'b0;
        m_q.delete();
        obs_prev_phase    = StInit;
        obs_prev_walk_led = 1'b0;
    endtask

    task automatic model_edge(input logic t, input logic w);
        bit     rise;
        bit     eff;
        state_e nxt;
        m_edge++;
        rise    = w && !m_wprev;
        m_wprev = w;
        eff     = 1'b0;
        while (m_q.size() > 0 && m_q[0] <= m_edge) begin
            if (m_q[0] == m_edge) eff = 1'b1;
            void'(m_q.pop_front());
        end
        // Synchroniser plus edge detect: a press sampled now is latched two edges later.
        if (rise) m_q.push_back(m_edge + 2);
        nxt = m_st;
        if (t) begin
            if (m_left == 1) begin
                nxt    = succ(m_st, m_pend, m_dir_ns);
                m_left = dur_of(nxt);
            end else begin
                m_left--;
            end
        end
        if (nxt == StWalk && m_st != StWalk) begin
            m_dir_ns = (m_st == StRedB);
            m_pend   = 1'b0;
        end else if (m_st != StWalk && eff) begin
            m_pend = 1'b1;
        end
        m_st = nxt;
    endtask

    // One clock: drive, model the edge, compare everything at the falling edge.
    task automatic cyc(input logic t, input logic w);
        logic [10:0] exp_v;
        logic [10:0] got_v;
        Tick = t;
        Walk = w;
        @(posedge Clk);
        model_edge(t, w);
        if (t) n_tick++;
        @(negedge Clk);
        exp_v = expect_vec();
        got_v = {LED_NS, LED_EW, Walk_LED, Walk_Pending, Phase};
        n_checks++;
        if (got_v !== exp_v) begin
            n_errors++;
            $display("FAIL cycle_model edge %0d: got ns/ew/wl/pend/phase %b required %b",
                     m_edge, got_v, exp_v);
        end
        if (Walk_LED && !obs_prev_walk_led) obs_walks++;
        phase_changed = (Phase != obs_prev_phase);
        if (obs_prev_phase == StWalk && Phase != StWalk) after_walk = Phase;
        if (obs_prev_phase == StRedB && Phase != StRedB) after_redb = Phase;
        if (Phase == StNsG && obs_prev_phase != StNsG) begin
            ns_entry_prev = ns_entry_last;
            ns_entry_last = n_tick;
        end
        obs_prev_phase    = Phase;
        obs_prev_walk_led = Walk_LED;
    endtask

    // Regular timebase: Tick on every fourth clock.
    task automatic cyc_auto(input logic w);
        last_was_tick = (slot == 0);
        slot          = (slot + 1) % 4;
        cyc(last_was_tick, w);
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                cyc_auto(1'b0);
                if (last_was_tick) break;
            end
        end
    endtask

    task automatic wait_phase(input state_e target, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 400; i++) begin
            cyc_auto(1'b0);
            if (phase_changed && Phase == target) begin
                hit = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!hit) begin
            n_errors++;
            $display("FAIL wait_%s: phase %0d never entered within 400 clocks, now %0d",
                     name, target, Phase);
        end
    endtask

    task automatic release_reset(input logic tick_during_sync);
        logic [2:0] ph_init;
        ph_init = StInit;
        Walk    = 1'b0;
        Tick    = tick_during_sync;
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
        Tick = 1'b0;
        n_checks++;
        if (Phase !== ph_init) begin
            n_errors++;
            $display("FAIL reset_sync_release: phase %0d required %0d", Phase, ph_init);
        end
        repeat (2) @(negedge Clk);
        model_reset();
        slot = 0;
    endtask

    task automatic test_reset();
        logic [10:0] got_v;
        logic [10:0] exp_v;
        Reset_n = 1'b0;
        Tick    = 1'b0;
        Walk    = 1'b0;
        repeat (3) @(negedge Clk);
        exp_v = {3'b100, 3'b100, 1'b0, 1'b0, phase_code(StInit)};
        got_v = {LED_NS, LED_EW, Walk_LED, Walk_Pending, Phase};
        n_checks++;
        if (got_v !== exp_v) begin
            n_errors++;
            $display("FAIL reset_state: got %b required %b", got_v, exp_v);
        end
        // Ticks during the two release clocks must not advance the controller.
        release_reset(1'b1);
    endtask

    task automatic test_free_run();
        n_tick        = 0;
        ns_entry_last = -1;
        ns_entry_prev = -1;
        run_ticks(1);
        n_checks++;
        if (Phase !== StNsG || ns_entry_last != 1) begin
            n_errors++;
            $display("FAIL init_to_nsg: phase %0d at tick %0d required %0d at tick 1",
                     Phase, ns_entry_last, StNsG);
        end
        run_ticks(34);
        n_checks++;
        if (ns_entry_last - ns_entry_prev != 16) begin
            n_errors++;
            $display("FAIL cycle_length: %0d ticks between NS_G entries required 16",
                     ns_entry_last - ns_entry_prev);
        end
    endtask

    task automatic test_press_ns_g();
        int base;
        int t_walk;
        bit got;
        wait_phase(StNsG, "nsg");
        base = obs_walks;
        got  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc_auto(1'b1);
            if (Walk_Pending) got = 1'b1;
        end
        cyc_auto(1'b0);
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL pending_latency: Walk_Pending 0 after 3 clocks required 1");
        end
        wait_phase(StWalk, "walk");
        t_walk = n_tick;
        n_checks++;
        if ({Walk_LED, Walk_Pending, LED_NS, LED_EW} !== {1'b1, 1'b0, 3'b100, 3'b100}) begin
            n_errors++;
            $display("FAIL walk_entry: led/pend/ns/ew %b required 1_0_100_100",
                     {Walk_LED, Walk_Pending, LED_NS, LED_EW});
        end
        wait_phase(StEwG, "ewg_after_walk");
        n_checks++;
        if (after_walk !== StEwG || n_tick - t_walk != W || obs_walks - base != 1) begin
            n_errors++;
            $display("FAIL walk_from_reda: next %0d ticks %0d walks %0d required %0d %0d 1",
                     after_walk, n_tick - t_walk, obs_walks - base, StEwG, W);
        end
    endtask

    task automatic test_held_press();
        int base;
        wait_phase(StNsG, "nsg_held");
        base = obs_walks;
        repeat (40) cyc_auto(1'b1);
        repeat (2) cyc_auto(1'b0);
        n_checks++;
        if (Walk_LED !== 1'b1) begin
            n_errors++;
            $display("FAIL held_in_walk: Walk_LED %b required 1", Walk_LED);
        end
        repeat (3) cyc_auto(1'b1);
        cyc_auto(1'b0);
        after_redb = StInit;
        run_ticks(40);
        n_checks++;
        if (obs_walks - base != 1 || after_redb !== StNsG || Walk_Pending !== 1'b0) begin
            n_errors++;
            $display("FAIL held_once: walks %0d after_redb %0d pend %b required 1 %0d 0",
                     obs_walks - base, after_redb, Walk_Pending, StNsG);
        end
    endtask

    task automatic test_reset_mid();
        wait_phase(StEwG, "ewg_reset");
        repeat (2) cyc_auto(1'b0);
        repeat (3) cyc_auto(1'b1);
        cyc_auto(1'b0);
        n_checks++;
        if (Walk_Pending !== 1'b1 || Phase !== StEwG) begin
            n_errors++;
            $display("FAIL pre_reset: pend %b phase %0d required 1 %0d",
                     Walk_Pending, Phase, StEwG);
        end
        #2;
        Reset_n = 1'b0;
        #1;
        n_checks++;
        if ({LED_NS, LED_EW, Walk_LED, Walk_Pending, Phase} !==
            {3'b100, 3'b100, 1'b0, 1'b0, phase_code(StInit)}) begin
            n_errors++;
            $display("FAIL async_reset: ns %b ew %b wl %b pend %b phase %0d required 100 100 0 0 0",
                     LED_NS, LED_EW, Walk_LED, Walk_Pending, Phase);
        end
        repeat (3) @(negedge Clk);
        release_reset(1'b0);
        run_ticks(1);
        n_checks++;
        if (Phase !== StNsG || LED_NS !== 3'b001) begin
            n_errors++;
            $display("FAIL post_reset_nsg: phase %0d ns %b required %0d 001",
                     Phase, LED_NS, StNsG);
        end
    endtask

    task automatic test_tick_stall();
        wait_phase(StNsY, "nsy");
        repeat (100) cyc(1'b0, 1'b0);
        n_checks++;
        if (Phase !== StNsY || LED_NS !== 3'b010 || LED_EW !== 3'b100) begin
            n_errors++;
            $display("FAIL stall_hold: phase %0d ns %b ew %b required %0d 010 100",
                     Phase, LED_NS, LED_EW, StNsY);
        end
        run_ticks(1);
        n_checks++;
        if (Phase !== StNsY) begin
            n_errors++;
            $display("FAIL stall_resume1: phase %0d required %0d", Phase, StNsY);
        end
        run_ticks(1);
        n_checks++;
        if (Phase !== StRedA) begin
            n_errors++;
            $display("FAIL stall_resume2: phase %0d required %0d", Phase, StRedA);
        end
    endtask

    task automatic test_coincident_press();
        int base;
        wait_phase(StNsG, "nsg_coinc");
        repeat (3) cyc_auto(1'b1);
        repeat (2) cyc_auto(1'b0);
        n_checks++;
        if (Walk_Pending !== 1'b1) begin
            n_errors++;
            $display("FAIL coinc_pending: pend %b required 1", Walk_Pending);
        end
        wait_phase(StRedA, "reda_coinc");
        // New press lands on the same edge that enters WALK.
        cyc_auto(1'b0);
        cyc_auto(1'b1);
        cyc_auto(1'b1);
        cyc_auto(1'b1);
        n_checks++;
        if (Phase !== StWalk || Walk_Pending !== 1'b0) begin
            n_errors++;
            $display("FAIL coinc_entry: phase %0d pend %b required %0d 0",
                     Phase, Walk_Pending, StWalk);
        end
        base = obs_walks;
        repeat (2) cyc_auto(1'b1);
        cyc_auto(1'b0);
        run_ticks(20);
        n_checks++;
        if (obs_walks != base || Walk_Pending !== 1'b0) begin
            n_errors++;
            $display("FAIL coinc_absorbed: extra walks %0d pend %b required 0 0",
                     obs_walks - base, Walk_Pending);
        end
    endtask

    task automatic test_random();
        logic wv;
        logic tv;
        wv = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            tv = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0) wv = ~wv;
            cyc(tv, wv);
        end
        cyc(1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_free_run();
        test_press_ns_g();
        test_held_press();
        test_reset_mid();
        test_tick_stall();
        test_coincident_press();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
